// File: rtl/audio_nios_timer_pkg.sv
// Shared definitions for the audio interval-timer Avalon-MM initiator:
// opcodes, timer register map, control bit positions, FSM states and
// small helpers for building bus cycles.
package audio_nios_timer_pkg;

   localparam logic [2:0] OP_CONFIG = 3'd0;
   localparam logic [2:0] OP_STOP   = 3'd1;
   localparam logic [2:0] OP_SNAP   = 3'd2;
   localparam logic [2:0] OP_WAIT   = 3'd3;
   localparam logic [2:0] OP_STATUS = 3'd4;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;
   localparam logic [2:0] ADDR_SNAPL   = 3'd4;
   localparam logic [2:0] ADDR_SNAPH   = 3'd5;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_PL,
      ST_WR_PH,
      ST_WR_CTRL,
      ST_WR_STOP,
      ST_WR_SNAP,
      ST_RD_SL,
      ST_RD_SH,
      ST_CAP_SH,
      ST_RD_ST,
      ST_CAP_ST,
      ST_POLL,
      ST_CLR_TO,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic        cs;
      logic        write_n;
      logic [2:0]  addr;
      logic [15:0] wdata;
   } bus_t;

   localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'h0000};

   function automatic bus_t bus_wr(input logic [2:0] addr, input logic [15:0] data);
      bus_t b;
      b.cs      = 1'b1;
      b.write_n = 1'b0;
      b.addr    = addr;
      b.wdata   = data;
      return b;
   endfunction

   function automatic bus_t bus_rd(input logic [2:0] addr);
      bus_t b;
      b.cs      = 1'b1;
      b.write_n = 1'b1;
      b.addr    = addr;
      b.wdata   = 16'h0000;
      return b;
   endfunction

   function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                             input logic cont, input logic ien);
      logic [15:0] w;
      w             = 16'h0000;
      w[CTRL_START] = start;
      w[CTRL_STOP]  = stop;
      w[CTRL_CONT]  = cont;
      w[CTRL_ITO]   = ien;
      return w;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/audio_nios_timer_master.sv
// Avalon-MM initiator for the audio interval timer. Runs one command at a
// time (config, stop, snapshot, wait-for-timeout, status) as a fixed
// sequence of single-cycle bus accesses and returns one response pulse.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | bus idle, cmd_ready high
// WR_PL      | write period[15:0] to PERIODL
// WR_PH      | write period[31:16] to PERIODH
// WR_CTRL    | write control with START plus cont/ien
// WR_STOP    | write control with STOP only (clears cont/ien)
// WR_SNAP    | write SNAPL to latch the counter snapshot
// RD_SL      | read SNAPL
// RD_SH      | read SNAPH, low half of snapshot arrives
// CAP_SH     | high half arrives, read held on SNAPH
// RD_ST      | read STATUS
// CAP_ST     | status arrives, read held on STATUS
// POLL       | read STATUS every cycle until timeout/irq or limit
// CLR_TO     | write STATUS to clear the timeout flag
// RESP       | one-cycle response, bus idle
module audio_nios_timer_master
   import audio_nios_timer_pkg::*;
#(
   parameter logic [31:0] WAIT_LIMIT = 32'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_period,
   input  logic        cmd_cont,
   input  logic        cmd_ien,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_data,
   output logic [2:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [15:0] m_writedata,
   input  logic [15:0] m_readdata,
   input  logic        timer_irq
);

   state_e      state_q, state_d;
   logic [31:0] period_q, period_d;
   logic        cont_q, cont_d;
   logic        ien_q, ien_d;
   logic [31:0] poll_cnt_q, poll_cnt_d;
   logic [15:0] snap_lo_q, snap_lo_d;
   logic        ready_q, ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   bus_t        bus_q, bus_d;
   logic        accept;
   logic        wait_hit;

   // Ready is registered so it only rises after a clock edge has seen reset released.
   assign cmd_ready = ready_q & reset_n;
   assign accept    = cmd_valid & cmd_ready;

   // The first POLL cycle's read data is stale, so exits are only honoured once a count exists.
   assign wait_hit  = (poll_cnt_q != 32'd0) && (m_readdata[0] || timer_irq);

   // Next-state, command latch and response datapath
   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      cont_d     = cont_q;
      ien_d      = ien_q;
      poll_cnt_d = poll_cnt_q;
      snap_lo_d  = snap_lo_q;
      rsp_err_d  = 1'b0;
      rsp_data_d = 32'd0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               period_d = cmd_period;
               cont_d   = cmd_cont;
               ien_d    = cmd_ien;
               case (cmd_op)
                  OP_CONFIG: state_d = ST_WR_PL;
                  OP_STOP:   state_d = ST_WR_STOP;
                  OP_SNAP:   state_d = ST_WR_SNAP;
                  OP_STATUS: state_d = ST_RD_ST;
                  OP_WAIT: begin
                     state_d    = ST_POLL;
                     poll_cnt_d = 32'd0;
                  end
                  default: begin
                     state_d   = ST_RESP;
                     rsp_err_d = 1'b1;
                  end
               endcase
            end
         end
         ST_WR_PL:   state_d = ST_WR_PH;
         ST_WR_PH:   state_d = ST_WR_CTRL;
         ST_WR_CTRL: state_d = ST_RESP;
         ST_WR_STOP: state_d = ST_RESP;
         ST_WR_SNAP: state_d = ST_RD_SL;
         ST_RD_SL:   state_d = ST_RD_SH;
         ST_RD_SH: begin
            snap_lo_d = m_readdata;
            state_d   = ST_CAP_SH;
         end
         ST_CAP_SH: begin
            rsp_data_d = {m_readdata, snap_lo_q};
            state_d    = ST_RESP;
         end
         ST_RD_ST:   state_d = ST_CAP_ST;
         ST_CAP_ST: begin
            rsp_data_d = {30'd0, m_readdata[1:0]};
            state_d    = ST_RESP;
         end
         ST_POLL: begin
            poll_cnt_d = sat_inc(poll_cnt_q);
            if (wait_hit) begin
               state_d = ST_CLR_TO;
            end else if ((WAIT_LIMIT != 32'd0) && (poll_cnt_d == WAIT_LIMIT)) begin
               state_d    = ST_RESP;
               rsp_err_d  = 1'b1;
               rsp_data_d = poll_cnt_d;
            end
         end
         ST_CLR_TO: begin
            rsp_data_d = poll_cnt_q;
            state_d    = ST_RESP;
         end
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Bus cycle for the state being entered, so the registered outputs line up with the state
   always_comb begin
      bus_d = BUS_IDLE;
      case (state_d)
         ST_WR_PL:   bus_d = bus_wr(ADDR_PERIODL, period_d[15:0]);
         ST_WR_PH:   bus_d = bus_wr(ADDR_PERIODH, period_d[31:16]);
         ST_WR_CTRL: bus_d = bus_wr(ADDR_CONTROL, ctrl_word(1'b1, 1'b0, cont_d, ien_d));
         ST_WR_STOP: bus_d = bus_wr(ADDR_CONTROL, ctrl_word(1'b0, 1'b1, 1'b0, 1'b0));
         ST_WR_SNAP: bus_d = bus_wr(ADDR_SNAPL, 16'h0000);
         ST_RD_SL:   bus_d = bus_rd(ADDR_SNAPL);
         ST_RD_SH:   bus_d = bus_rd(ADDR_SNAPH);
         ST_CAP_SH:  bus_d = bus_rd(ADDR_SNAPH);
         ST_RD_ST:   bus_d = bus_rd(ADDR_STATUS);
         ST_CAP_ST:  bus_d = bus_rd(ADDR_STATUS);
         ST_POLL:    bus_d = bus_rd(ADDR_STATUS);
         ST_CLR_TO:  bus_d = bus_wr(ADDR_STATUS, 16'h0000);
         default:    bus_d = BUS_IDLE;
      endcase
   end

   // Response and ready strobes follow the state being entered
   always_comb begin
      rsp_valid_d = (state_d == ST_RESP);
      ready_d     = (state_d == ST_IDLE);
   end

   // Registers with synchronous active-low reset; reset drops any command in flight
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         period_q    <= 32'd0;
         cont_q      <= 1'b0;
         ien_q       <= 1'b0;
         poll_cnt_q  <= 32'd0;
         snap_lo_q   <= 16'h0000;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= 32'd0;
         bus_q       <= BUS_IDLE;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         cont_q      <= cont_d;
         ien_q       <= ien_d;
         poll_cnt_q  <= poll_cnt_d;
         snap_lo_q   <= snap_lo_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
         bus_q       <= bus_d;
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_err      = rsp_err_q;
   assign rsp_data     = rsp_data_q;
   assign m_chipselect = bus_q.cs;
   assign m_write_n    = bus_q.write_n;
   assign m_address    = bus_q.addr;
   assign m_writedata  = bus_q.wdata;

endmodule
